// File: rtl/div_shift5.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Unsigned DW-bit dividend by SW-bit divisor with start/done handshake.
module div_shift5 #(
  parameter int DW = 30,
  parameter int SW = 5
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_START,
  input  logic [DW-1:0] I_IN1,
  input  logic [SW-1:0] I_IN2,
  output logic          O_BUSY,
  output logic          O_DONE,
  output logic [DW-1:0] O_QUO,
  output logic [SW-1:0] O_REM,
  output logic          O_DIV0
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [SW-1:0] dvs_q, dvs_d;
  logic [SW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;

  logic [SW:0]   p_ext;
  logic          ge;
  logic [SW-1:0] p_sub;
  logic [SW-1:0] p_n;
  logic [DW-1:0] dvd_n;

  // Difference always fits SW bits when it is taken, so
  // the wrap of the narrow subtract is harmless.
  assign p_ext = {p_q, dvd_q[DW-1]};
  assign ge    = p_ext >= {1'b0, dvs_q};
  assign p_sub = p_ext[SW-1:0] - dvs_q;
  assign p_n   = ge ? p_sub : p_ext[SW-1:0];
  assign dvd_n = {dvd_q[DW-2:0], ge};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    unique case (state_q)
      BUSY: begin
        dvd_d = dvd_n;
        p_d   = p_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW-1)) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = dvd_n;
          rem_d   = p_n;
          div0_d  = 1'b0;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (I_START) begin
          dvd_d = I_IN1;
          dvs_d = I_IN2;
          p_d   = '0;
          cnt_d = '0;
          if (I_IN2 == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = '0;
            div0_d  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign O_BUSY = (state_q == BUSY);
  assign O_DONE = (state_q == DONE);
  assign O_QUO  = quo_q;
  assign O_REM  = rem_q;
  assign O_DIV0 = div0_q;

endmodule
